// File: rtl/puf_chal_pkg.sv
// Shared types and default sizing for the PUF challenge dispatcher.
package puf_chal_pkg;

    typedef enum logic [1:0] {StWarmup, StLoad, StServe} disp_state_t;

    localparam int unsigned DefRngW   = 1024;
    localparam int unsigned DefChalW  = 64;
    localparam int unsigned DefNumReq = 4;

    function automatic int unsigned slices(input int unsigned rng_w, input int unsigned chal_w);
        return rng_w / chal_w;
    endfunction

endpackage

// File: rtl/puf_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after the pointer, cyclically.
module puf_rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDW-1:0]     rr_ptr_i,
    output logic               any_o,
    output logic [IDW-1:0]     idx_o,
    output logic [NUM_REQ-1:0] onehot_o
);

    int unsigned j;

    always_comb begin
        any_o    = 1'b0;
        idx_o    = '0;
        onehot_o = '0;
        j        = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            j = (int'(rr_ptr_i) + k) % NUM_REQ;
            if (!any_o && req_i[j]) begin
                any_o       = 1'b1;
                idx_o       = IDW'(j);
                onehot_o[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/puf_chal_dispatcher.sv
// Hands out non-overlapping slices of a snapshotted random word to round-robin requesters.
// Define PUF_CHAL_DISPATCHER_STATS_EN to add the issued_cnt/reload_cnt statistics ports.
module puf_chal_dispatcher
    import puf_chal_pkg::*;
#(
    parameter int unsigned NUM_REQ = DefNumReq,
    parameter int unsigned CHAL_W  = DefChalW,
    parameter int unsigned RNG_W   = DefRngW,
    parameter int unsigned WARMUP  = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [RNG_W-1:0]           rng_word,
    input  logic [NUM_REQ-1:0]         req,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [CHAL_W-1:0]          chal,
    output logic                       chal_valid,
    output logic [$clog2(NUM_REQ)-1:0] chal_id,
    output logic                       ready
`ifdef PUF_CHAL_DISPATCHER_STATS_EN
    ,
    output logic [31:0]                issued_cnt,
    output logic [31:0]                reload_cnt
`endif
);

    localparam int unsigned SLICES = slices(RNG_W, CHAL_W);
    localparam int unsigned IDW    = $clog2(NUM_REQ);
    localparam int unsigned SIW    = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam int unsigned WCW    = $clog2(WARMUP + 1);

    disp_state_t        state_q, state_d;
    logic [WCW-1:0]     warm_cnt_q, warm_cnt_d;
    logic [RNG_W-1:0]   hold_q, hold_d;
    logic [SIW-1:0]     slice_idx_q, slice_idx_d;
    logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [CHAL_W-1:0]  chal_q, chal_d;
    logic               valid_q, valid_d;
    logic [IDW-1:0]     id_q, id_d;

    logic               arb_any;
    logic [IDW-1:0]     arb_idx;
    logic [NUM_REQ-1:0] arb_onehot;

    puf_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req_i    (req),
        .rr_ptr_i (rr_ptr_q),
        .any_o    (arb_any),
        .idx_o    (arb_idx),
        .onehot_o (arb_onehot)
    );

    always_comb begin
        state_d     = state_q;
        warm_cnt_d  = warm_cnt_q;
        hold_d      = hold_q;
        slice_idx_d = slice_idx_q;
        rr_ptr_d    = rr_ptr_q;
        gnt_d       = '0;
        valid_d     = 1'b0;
        chal_d      = chal_q;
        id_d        = id_q;
        unique case (state_q)
            StWarmup: begin
                warm_cnt_d = warm_cnt_q + WCW'(1);
                if (warm_cnt_q == WCW'(WARMUP - 1)) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                hold_d      = rng_word;
                slice_idx_d = '0;
                state_d     = StServe;
            end
            StServe: begin
                if (arb_any) begin
                    gnt_d    = arb_onehot;
                    valid_d  = 1'b1;
                    chal_d   = hold_q[slice_idx_q*CHAL_W +: CHAL_W];
                    id_d     = arb_idx;
                    rr_ptr_d = (arb_idx == IDW'(NUM_REQ - 1)) ? '0 : arb_idx + IDW'(1);
                    // The last slice of this snapshot forces a reload before the next grant.
                    if (slice_idx_q == SIW'(SLICES - 1)) begin
                        state_d = StLoad;
                    end else begin
                        slice_idx_d = slice_idx_q + SIW'(1);
                    end
                end
            end
            default: state_d = StWarmup;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StWarmup;
            warm_cnt_q  <= '0;
            hold_q      <= '0;
            slice_idx_q <= '0;
            rr_ptr_q    <= '0;
            gnt_q       <= '0;
            valid_q     <= 1'b0;
            chal_q      <= '0;
            id_q        <= '0;
        end else begin
            state_q     <= state_d;
            warm_cnt_q  <= warm_cnt_d;
            hold_q      <= hold_d;
            slice_idx_q <= slice_idx_d;
            rr_ptr_q    <= rr_ptr_d;
            gnt_q       <= gnt_d;
            valid_q     <= valid_d;
            chal_q      <= chal_d;
            id_q        <= id_d;
        end
    end

    assign gnt        = gnt_q;
    assign chal       = chal_q;
    assign chal_valid = valid_q;
    assign chal_id    = id_q;
    assign ready      = (state_q == StServe);

`ifdef PUF_CHAL_DISPATCHER_STATS_EN
    logic [31:0] issued_q, reload_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            issued_q <= '0;
            reload_q <= '0;
        end else begin
            if (valid_d && (issued_q != '1)) begin
                issued_q <= issued_q + 32'd1;
            end
            if ((state_q == StLoad) && (reload_q != '1)) begin
                reload_q <= reload_q + 32'd1;
            end
        end
    end

    assign issued_cnt = issued_q;
    assign reload_cnt = reload_q;
`endif

endmodule

// File: tb/tb_puf_chal_dispatcher.sv
// Scoreboard bench for puf_chal_dispatcher: directed tests push expected grants, a monitor checks them.
module tb_puf_chal_dispatcher;

    localparam int NR = 4;
    localparam int CW = 64;
    localparam int RW = 1024;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [RW-1:0] rng_word = '0;
    logic [NR-1:0] req = '0;
    logic [NR-1:0] gnt;
    logic [CW-1:0] chal;
    logic          chal_valid;
    logic [1:0]    chal_id;
    logic          ready;
`ifdef PUF_CHAL_DISPATCHER_STATS_EN
    logic [31:0]   issued_cnt;
    logic [31:0]   reload_cnt;
`endif

    puf_chal_dispatcher dut (
        .clk        (clk),
        .reset      (reset),
        .rng_word   (rng_word),
        .req        (req),
        .gnt        (gnt),
        .chal       (chal),
        .chal_valid (chal_valid),
        .chal_id    (chal_id),
        .ready      (ready)
`ifdef PUF_CHAL_DISPATCHER_STATS_EN
        ,
        .issued_cnt (issued_cnt),
        .reload_cnt (reload_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          ed;
        int          id;
        logic [63:0] chal;
    } exp_t;

    exp_t q[$];
    int   e_n;
    int   n_chk = 0;
    int   n_pass = 0;
    int   cur_base = 0;

    // Edges counted from reset release; edge 1 is the first posedge with reset high.
    always @(posedge clk or negedge reset) begin
        if (!reset) e_n <= 0;
        else        e_n <= e_n + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, e_n);
    endtask

    function automatic logic [RW-1:0] word_for(input int n);
        logic [RW-1:0] w;
        for (int k = 0; k < RW / CW; k++) w[k*CW +: CW] = 64'(n * 16 + k);
        return w;
    endfunction

    // With a request present every SERVE cycle, grant g lands after edge 18+g+g/16.
    task automatic push(input int g, input int id);
        exp_t e;
        e.ed   = 18 + g + g / 16;
        e.id   = id;
        e.chal = 64'((cur_base + g / 16) * 16 + g % 16);
        q.push_back(e);
    endtask

    task automatic run_to(input int e);
        while (e_n < e) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic chk_reset_outs();
        chk("rst_gnt", 64'(gnt), 64'd0);
        chk("rst_chal", chal, 64'd0);
        chk("rst_valid", 64'(chal_valid), 64'd0);
        chk("rst_id", 64'(chal_id), 64'd0);
        chk("rst_ready", 64'(ready), 64'd0);
    endtask

    task automatic start(input int base, input logic [NR-1:0] pat);
        cur_base = base;
        req      = pat;
        reset    = 1'b1;
    endtask

    task automatic finish_test();
        reset = 1'b0;
        #1;
        chk_reset_outs();
        chk("queue_drained", 64'(q.size()), 64'd0);
        q.delete();
        req = '0;
        @(posedge clk);
        #2;
    endtask

    // Valid snapshot only in the cycle before a predicted LOAD edge, junk otherwise.
    initial begin
        int nx;
        forever begin
            @(posedge clk);
            #2;
            nx = e_n + 1;
            if (reset && nx >= 17 && (nx - 17) % 17 == 0) begin
                rng_word = word_for(cur_base + (nx - 17) / 17);
            end else begin
                for (int i = 0; i < RW / 32; i++) rng_word[i*32 +: 32] = $urandom;
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset && (chal_valid || gnt != '0)) begin
                if (q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_grant: got gnt=%b id=%0d at edge %0d, required none",
                             gnt, chal_id, e_n);
                end else begin
                    e = q.pop_front();
                    chk("grant_edge", 64'(e_n), 64'(e.ed));
                    chk("gnt", 64'(gnt), 64'(1) << e.id);
                    chk("chal_id", 64'(chal_id), 64'(e.id));
                    chk("chal", chal, e.chal);
                    chk("chal_valid", 64'(chal_valid), 64'd1);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #2;
        chk_reset_outs();

        // Warm-up latency, single requester 2.
        start(0, 4'b0100);
        for (int g = 0; g < 16; g++) push(g, 2);
        run_to(35);
        finish_test();

        // Round robin across all four, spanning two reloads.
        start(10, 4'b1111);
        for (int g = 0; g < 40; g++) push(g, g % 4);
        run_to(18);
        chk("ready_serve", 64'(ready), 64'd1);
        run_to(59);
`ifdef PUF_CHAL_DISPATCHER_STATS_EN
        chk("issued_cnt", 64'(issued_cnt), 64'd40);
        chk("reload_cnt", 64'(reload_cnt), 64'd3);
`endif
        run_to(60);
        finish_test();

        // Single requester back-to-back.
        start(20, 4'b1000);
        for (int g = 0; g < 32; g++) push(g, 3);
        run_to(52);
        finish_test();

        // Fairness: req[2] pulses once against a persistent req[0].
        start(30, 4'b0001);
        for (int g = 0; g < 21; g++) push(g, (g == 5) ? 2 : 0);
        run_to(22);
        req[2] = 1'b1;
        run_to(23);
        req[2] = 1'b0;
        run_to(40);
        finish_test();

        // Reset after the fifth grant, then a fresh warm-up and load.
        start(40, 4'b1111);
        for (int g = 0; g < 4; g++) push(g, g % 4);
        run_to(22);
        chk("gnt_pre_reset", 64'(gnt), 64'd1);
        chk("ready_pre_reset", 64'(ready), 64'd1);
        finish_test();
        start(50, 4'b1111);
        for (int g = 0; g < 7; g++) push(g, g % 4);
        run_to(25);
        finish_test();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/puf_chal_dispatcher.md
Name: puf_chal_dispatcher

Overview:
- Shares the free-running 1024-bit random word among NUM_REQ PUF challenge requesters.
- Snapshots the word into a holding register, then issues it as non-overlapping CHAL_W-bit challenge slices through a round-robin request/grant handshake.
- Reloads the holding register once every slice has been issued.
- Sits between the random-stream generator and the arbiter-PUF challenge/LUT drivers.

Parameters:
- NUM_REQ, 4: number of requesters (≥2).
- CHAL_W, 64: challenge width; RNG_W % CHAL_W must equal 0.
- RNG_W, 1024: random word width.
- WARMUP, 16: cycles discarded after reset while the generator leaves its all-ones seed (≥1).

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-low reset.
- rng_word  input  RNG_W  random word; changes every cycle.
- req  input  NUM_REQ  per-requester level request.
- gnt  output  NUM_REQ  one-hot grant pulse.
- chal  output  CHAL_W  challenge data, valid with gnt.
- chal_valid  output  1  high when any gnt bit is high.
- chal_id  output  $clog2(NUM_REQ)  index of the granted requester.
- ready  output  1  high in SERVE state.

Behaviour:
- Derived constant: SLICES = RNG_W/CHAL_W (16 by default).
- Reset (async, active-low): state=WARMUP, warm_cnt=0, hold=0, slice_idx=0, rr_ptr=0. Outputs: gnt=0, chal=0, chal_valid=0, chal_id=0, ready=0.
- WARMUP:
  - warm_cnt increments each edge.
  - On the edge where warm_cnt==WARMUP-1, go to LOAD.
  - req is ignored.
- LOAD (exactly one cycle): hold<=rng_word, slice_idx<=0, go to SERVE. No grant is issued.
- SERVE, arbitration and grant:
  - ready=1.
  - Each edge, if req!=0: pick the first set req bit at or after rr_ptr, cyclically.
  - Outputs are registered, so they are visible the cycle after req is sampled: gnt[i]=1, chal=hold[slice_idx*CHAL_W +: CHAL_W], chal_id=i, chal_valid=1.
  - Then rr_ptr<=(i+1)%NUM_REQ and slice_idx++.
  - If req==0: gnt=0, chal_valid=0, chal holds its last value.
- SERVE, exhaustion: the edge that issues slice SLICES-1 goes to LOAD. The following cycle issues no grant.
- Grant rate and latency: at most one grant per cycle. Grant latency is 1 cycle.
- Handshake:
  - A requester holds req until it sees gnt, and may drop req in the gnt cycle.
  - A req still high during its gnt cycle is treated as a new request; round-robin then gives other active requesters priority first.
- Slice usage:
  - Slice 0 = hold[CHAL_W-1:0]; slices are issued in ascending order.
  - Each slice is issued exactly once; no slice is reused across loads.
  - Throughput is SLICES grants per SLICES+1 cycles.
- Reset mid-operation:
  - Outputs clear immediately.
  - A pending or in-flight grant is lost; no replay.
  - After release the full WARMUP sequence repeats.
- Timing from reset release: with req held from release, the first gnt is high after edge WARMUP+2.

Optional Feature:
- Macro: PUF_CHAL_DISPATCHER_STATS_EN.
- Defined: adds output ports issued_cnt[31:0] and reload_cnt[31:0].
  - issued_cnt increments on each grant.
  - reload_cnt increments on each LOAD.
  - Both saturate at all-ones and reset to 0.
- Undefined: neither port nor its counters exist; all other behaviour is identical.

Decomposition:
- Package puf_chal_pkg holds:
  - the state enum typedef disp_state_t {WARMUP, LOAD, SERVE};
  - default constants RNG_W, CHAL_W, NUM_REQ;
  - a SLICES helper function.
- Sub-module puf_rr_arbiter (NUM_REQ param):
  - inputs: req, rr_ptr;
  - outputs: any, idx, one-hot;
  - combinational.
- Dispatcher owns all state, registers and the pointer update.

Test Plan:
- Warm-up latency: WARMUP=16, req=4'b0100 from reset release. No gnt for edges 1–18; gnt=4'b0100, chal_id=2 and chal=slice 0 after edge 18.
- Round-robin and reload:
  - Bench drives rng_word so that, at load n, slice k = 64'(n*16+k). req=4'b1111 held.
  - Expected: gnt cycles 0,1,2,3,0,… with chal = 0,1,…,15.
  - Then one idle cycle (LOAD), then chal = 16,17,… and rr continues from requester 0.
- Single requester back-to-back: req=4'b1000 held. Expected: 16 consecutive gnt=4'b1000 cycles, 1 gap, repeat; chal_id=3 throughout.
- Fairness under contention: req[0] always high, req[2] asserted once. req[2] is granted within 2 grants of its assertion and drops req on gnt. After that only req[0] is granted.
- Reset mid-SERVE:
  - Assert reset after 5 grants: gnt, chal_valid and ready go 0 combinationally with reset assertion.
  - After release: WARMUP repeats and the first chal is slice 0 of a new load.
- STATS_EN build: after 40 grants with req=4'b1111 held from the 1st LOAD, issued_cnt=40 and reload_cnt=3.
